// File: rtl/debug_probe_mux.sv
// Board-level debug observation block. Puts one of NUM_CHANNELS probe words on a
// registered display output. The channel is chosen by manual select, by a timed
// auto-scan, or by a debounced step button. A debounced freeze button toggles between
// live probe data and a snapshot of all channels taken at the moment of freezing.
module debug_probe_mux #(
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_CHANNELS    = 4,
    parameter int SEL_WIDTH       = $clog2(NUM_CHANNELS),
    parameter int DWELL_CYCLES    = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic                               clock,
    input  logic                               isReset,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] probeBus,
    input  logic [SEL_WIDTH-1:0]               select,
    input  logic [1:0]                         mode,
    input  logic                               freezeButton,
    input  logic                               stepButton,
    output logic [DATA_WIDTH-1:0]              outputValue,
    output logic [SEL_WIDTH-1:0]               channelIndex,
    output logic                               frozen
);

    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [SEL_WIDTH-1:0] LAST_IDX   = SEL_WIDTH'(NUM_CHANNELS - 1);
    localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [DB_W-1:0]      DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

    // Mode 2'b11 is folded into manual, so only three behaviours exist.
    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_STEP   = 2'd2
    } scan_mode_e;

    // Button bit 0 = freeze, bit 1 = step.
    logic [1:0]             btn_raw;
    logic [1:0]             sync1_q, sync1_d;
    logic [1:0]             sync2_q, sync2_d;
    logic [1:0]             lvl_q, lvl_d;
    logic [1:0]             lvl_prev_q, lvl_prev_d;
    logic [1:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [1:0]             btn_rise;
    logic                   freeze_pulse;
    logic                   step_pulse;

    scan_mode_e             eff_mode;
    scan_mode_e             mode_q, mode_d;
    logic                   mode_changed;
    logic [SEL_WIDTH-1:0]   scan_idx_q, scan_idx_d;
    logic [SEL_WIDTH-1:0]   scan_next;
    logic [DWELL_W-1:0]     dwell_q, dwell_d;
    logic [DWELL_W-1:0]     dwell_base;

    logic                                frozen_q, frozen_d;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]  snap_q, snap_d;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]  src;
    logic [SEL_WIDTH-1:0]                chan_idx_q, chan_idx_d;
    logic [DATA_WIDTH-1:0]               out_q, out_d;

    assign btn_raw      = {stepButton, freezeButton};
    assign btn_rise     = lvl_q & ~lvl_prev_q;
    assign freeze_pulse = btn_rise[0];
    assign step_pulse   = btn_rise[1];

    assign outputValue  = out_q;
    assign channelIndex = chan_idx_q;
    assign frozen       = frozen_q;

    // Synchronise each button, then accept a new level only after it has differed
    // from the current debounced level for DEBOUNCE_CYCLES consecutive samples.
    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        lvl_prev_d = lvl_q;
        lvl_d      = lvl_q;
        db_cnt_d   = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != lvl_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    lvl_d[b] = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    // Scan index and dwell counter; a mode change restarts the dwell from zero but
    // keeps the scan index, and the cycle of the change counts as the first dwell clock.
    always_comb begin
        case (mode)
            2'b01:   eff_mode = MODE_AUTO;
            2'b10:   eff_mode = MODE_STEP;
            default: eff_mode = MODE_MANUAL;
        endcase
        mode_d       = eff_mode;
        mode_changed = (eff_mode != mode_q);
        scan_next    = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + SEL_WIDTH'(1);
        dwell_base   = mode_changed ? '0 : dwell_q;
        scan_idx_d   = scan_idx_q;
        dwell_d      = dwell_base;
        case (eff_mode)
            MODE_AUTO: begin
                if (dwell_base == DWELL_LAST) begin
                    dwell_d    = '0;
                    scan_idx_d = scan_next;
                end else begin
                    dwell_d = dwell_base + DWELL_W'(1);
                end
            end
            MODE_STEP: begin
                dwell_d = '0;
                if (step_pulse) begin
                    scan_idx_d = scan_next;
                end
            end
            default: begin
                dwell_d = dwell_base;
            end
        endcase
    end

    // Freeze toggle, snapshot capture and the registered display selection.
    always_comb begin
        frozen_d   = frozen_q ^ freeze_pulse;
        snap_d     = (freeze_pulse && !frozen_q) ? probeBus : snap_q;
        chan_idx_d = (eff_mode == MODE_MANUAL) ? select : scan_idx_q;
        src        = frozen_d ? snap_d : probeBus;
        out_d      = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (chan_idx_d == SEL_WIDTH'(k)) begin
                out_d = src[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clock or negedge isReset) begin
        if (!isReset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            db_cnt_q   <= '0;
            mode_q     <= MODE_MANUAL;
            scan_idx_q <= '0;
            dwell_q    <= '0;
            frozen_q   <= 1'b0;
            snap_q     <= '0;
            chan_idx_q <= '0;
            out_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_prev_d;
            db_cnt_q   <= db_cnt_d;
            mode_q     <= mode_d;
            scan_idx_q <= scan_idx_d;
            dwell_q    <= dwell_d;
            frozen_q   <= frozen_d;
            snap_q     <= snap_d;
            chan_idx_q <= chan_idx_d;
            out_q      <= out_d;
        end
    end

endmodule
